branch_sequencer: RTL and testbench

Multicycle branch-resolution controller for the 16-bit MIPS CPU. Accepts one branch/jump request from decode, then time-shares a single 16-bit adder/subtractor: first for the operand comparison (A−B, zero/sign/overflow), then for the target address (PC+1+offset). It returns a registered redirect to the fetch stage, with a one-cycle flush pulse on taken branches, and keeps saturating branch statistics.

---
 rtl/branch_sequencer_pkg.sv | 31 +++
 rtl/branch_sequencer_addsub16.sv | 23 ++
 rtl/branch_sequencer.sv | 119 +++++++++++
 tb/tb_branch_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_sequencer_pkg.sv
// Shared encodings for the branch sequencer: branch ops, FSM states and the
// taken-resolution rule applied to the registered compare flags.
package branch_defs;

  typedef enum logic [1:0] {
    OP_BEQ = 2'b00,
    OP_BNE = 2'b01,
    OP_BLT = 2'b10,
    OP_J   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CMP  = 2'b01,
    S_TGT  = 2'b10,
    S_RESP = 2'b11
  } state_e;

  // Signed less-than is the sign of (X-Y) corrected by signed overflow.
  function automatic logic resolve_taken(op_e op, logic zero, logic neg, logic ovf);
    logic t;
    case (op)
      OP_BEQ:  t = zero;
      OP_BNE:  t = !zero;
      OP_BLT:  t = neg ^ ovf;
      default: t = 1'b1;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_sequencer_addsub16.sv
// Shared adder/subtractor: sub=1 computes a + ~b + 1, otherwise a + b.
module addsub16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  assign b_eff = sub ? ~b : b;
  assign full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign sum   = full[WIDTH-1:0];
  assign cout  = full[WIDTH];
  // Overflow: operands of equal sign produced a result of the other sign.
  assign ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/branch_sequencer.sv
// Multicycle branch resolver: one shared adder does the compare in CMP and the
// target add in TGT; the redirect is held in RESP until fetch stops stalling.
module branch_sequencer
  import branch_defs::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic [WIDTH-1:0] pc_plus1,
  input  logic [WIDTH-1:0] offset,
  input  logic             stall,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             taken,
  output logic             flush,
  output logic             busy,
  output logic [15:0]      branch_count,
  output logic [15:0]      taken_count
);

  state_e           state_q, state_d;
  op_e              op_q;
  logic [WIDTH-1:0] x_q, y_q, pc_q, off_q;
  logic             zero_q, neg_q, ovf_q;
  logic [WIDTH-1:0] rpc_q;
  logic             taken_q;
  logic [15:0]      branch_count_q, taken_count_q;

  logic [WIDTH-1:0] adder_a, adder_b, adder_sum;
  logic             adder_sub, adder_ovf, adder_cout_unused;
  logic             retire;
  logic             taken_now;

  // Adder operands are selected purely by state.
  assign adder_sub = (state_q == S_CMP);
  assign adder_a   = adder_sub ? x_q : pc_q;
  assign adder_b   = adder_sub ? y_q : off_q;

  addsub16 #(.WIDTH(WIDTH)) u_addsub (
    .a    (adder_a),
    .b    (adder_b),
    .sub  (adder_sub),
    .sum  (adder_sum),
    .cout (adder_cout_unused),
    .ovf  (adder_ovf)
  );

  assign retire    = (state_q == S_RESP) && !stall;
  assign taken_now = resolve_taken(op_q, zero_q, neg_q, ovf_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = S_CMP;
      S_CMP:   state_d = S_TGT;
      S_TGT:   state_d = S_RESP;
      S_RESP:  if (!stall) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      op_q           <= OP_BEQ;
      x_q            <= '0;
      y_q            <= '0;
      pc_q           <= '0;
      off_q          <= '0;
      zero_q         <= 1'b0;
      neg_q          <= 1'b0;
      ovf_q          <= 1'b0;
      rpc_q          <= '0;
      taken_q        <= 1'b0;
      branch_count_q <= '0;
      taken_count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && req_valid) begin
        op_q  <= op_e'(req_op);
        x_q   <= rs_val;
        y_q   <= rt_val;
        pc_q  <= pc_plus1;
        off_q <= offset;
      end
      if (state_q == S_CMP) begin
        zero_q <= (adder_sum == '0);
        neg_q  <= adder_sum[WIDTH-1];
        ovf_q  <= adder_ovf;
      end
      if (state_q == S_TGT) begin
        taken_q <= taken_now;
        rpc_q   <= taken_now ? adder_sum : pc_q;
      end
      // Statistics stick at all-ones instead of wrapping.
      if (retire) begin
        if (branch_count_q != 16'hFFFF) branch_count_q <= branch_count_q + 16'd1;
        if (taken_q && taken_count_q != 16'hFFFF) taken_count_q <= taken_count_q + 16'd1;
      end
    end
  end

  assign req_ready      = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign redirect_valid = (state_q == S_RESP);
  assign redirect_pc    = rpc_q;
  assign taken          = taken_q;
  // Flush marks the cycle in which fetch actually consumes a taken redirect.
  assign flush          = retire && taken_q;
  assign branch_count   = branch_count_q;
  assign taken_count    = taken_count_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench: directed test-plan cases plus randomized requests,
// compared every cycle against a transaction-level model.
module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] rs_val, rt_val, pc_plus1, offset;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        taken;
  logic        flush;
  logic        busy;
  logic [15:0] branch_count, taken_count;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model state: cycles since acceptance (0 = idle, 3 = redirect presented).
  int          m_phase = 0;
  logic [15:0] m_pc = '0, m_bc = '0, m_tc = '0;
  logic        m_tk = 1'b0;

  branch_sequencer #(.WIDTH(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .rs_val         (rs_val),
    .rt_val         (rt_val),
    .pc_plus1       (pc_plus1),
    .offset         (offset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .taken          (taken),
    .flush          (flush),
    .busy           (busy),
    .branch_count   (branch_count),
    .taken_count    (taken_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic model_taken(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y);
    case (op)
      2'b00:   return x == y;
      2'b01:   return x != y;
      2'b10:   return $signed(x) < $signed(y);
      default: return 1'b1;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_bc = '0; m_tc = '0; m_pc = '0; m_tk = 1'b0;
    end else begin
      case (m_phase)
        0: if (req_valid) begin
          m_tk    = model_taken(req_op, rs_val, rt_val);
          m_pc    = m_tk ? 16'(pc_plus1 + offset) : pc_plus1;
          m_phase = 1;
        end
        1: m_phase = 2;
        2: m_phase = 3;
        default: if (!stall) begin
          if (m_bc != 16'hFFFF) m_bc = m_bc + 16'd1;
          if (m_tk && m_tc != 16'hFFFF) m_tc = m_tc + 16'd1;
          m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      check("req_ready", req_ready, m_phase == 0);
      check("busy", busy, m_phase != 0);
      check("redirect_valid", redirect_valid, m_phase == 3);
      if (m_phase == 3) begin
        check("redirect_pc", redirect_pc, m_pc);
        check("taken", taken, m_tk);
      end
      check("flush", flush, (m_phase == 3) && m_tk && !stall);
      check("branch_count", branch_count, m_bc);
      check("taken_count", taken_count, m_tc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_fields();
    req_op   = 2'($urandom_range(0, 3));
    rs_val   = 16'($urandom);
    rt_val   = 16'($urandom);
    pc_plus1 = 16'($urandom);
    offset   = 16'($urandom);
  endtask

  // Issue one request and run it to retirement, holding stall for nstall
  // RESP cycles and toggling junk req_valid/data while busy.
  task automatic do_req(input logic [1:0] op, input logic [15:0] rs, input logic [15:0] rt,
                        input logic [15:0] pc, input logic [15:0] off, input int nstall,
                        input bit chk, input logic [15:0] epc, input logic etk);
    int k, lat, guard, stl;
    bit seen;
    req_op = op; rs_val = rs; rt_val = rt; pc_plus1 = pc; offset = off;
    req_valid = 1'b1; stall = 1'b0;
    k = 0;
    do begin
      step();
      k++;
    end while (m_phase != 1 && k < 10);
    if (m_phase != 1) begin
      check("accept_timeout", 32'(m_phase), 32'd1);
      req_valid = 1'b0;
      return;
    end
    lat = 0; seen = 1'b0; stl = nstall; guard = 0;
    while (guard < 60) begin
      if (m_phase == 3) begin
        stall = (stl > 0);
        if (stl > 0) stl--;
      end else begin
        stall = 1'($urandom_range(0, 1));
      end
      randomize_fields();
      req_valid = (m_phase == 3 && !stall) ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (chk) begin
        if (m_phase == 3 && !seen) begin
          seen = 1'b1;
          check("latency", 32'(lat), 32'd2);
          check("lit_redirect_pc", redirect_pc, epc);
          check("lit_taken", taken, etk);
        end
        if (!seen) lat++;
        if (m_phase == 3 && stall) check("lit_flush_stalled", flush, 1'b0);
        if (m_phase == 3 && !stall) check("lit_flush", flush, etk);
      end
      step();
      guard++;
      if (m_phase == 0) break;
    end
    if (m_phase != 0) check("retire_timeout", 32'(m_phase), 32'd0);
    req_valid = 1'b0;
    stall = 1'b0;
    $display("req op=%0d rs=%h rt=%h pc=%h off=%h stall=%0d -> pc=%h taken=%0d bc=%h tc=%h",
             op, rs, rt, pc, off, nstall, m_pc, m_tk, branch_count, taken_count);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; stall = 1'b0;
    req_op = '0; rs_val = '0; rt_val = '0; pc_plus1 = '0; offset = '0;
    cmp_en = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_redirect_valid", redirect_valid, 1'b0);
    check("rst_redirect_pc", redirect_pc, 16'h0000);
    check("rst_taken", taken, 1'b0);
    check("rst_flush", flush, 1'b0);
    check("rst_counts", {branch_count, taken_count}, 32'h0);
    step();
    reset = 1'b0;

    do_req(2'b00, 16'h1234, 16'h1234, 16'h0010, 16'h0005, 0, 1'b1, 16'h0015, 1'b1);
    check("beq_counts", {branch_count, taken_count}, {16'd1, 16'd1});
    do_req(2'b01, 16'h1234, 16'h1234, 16'h0020, 16'h0007, 0, 1'b1, 16'h0020, 1'b0);
    check("bne_counts", {branch_count, taken_count}, {16'd2, 16'd1});
    do_req(2'b10, 16'h8000, 16'h0001, 16'h0100, 16'hFFFE, 0, 1'b1, 16'h00FE, 1'b1);
    do_req(2'b10, 16'h7FFF, 16'hFFFF, 16'h0200, 16'h0010, 1, 1'b1, 16'h0200, 1'b0);
    do_req(2'b11, 16'hABCD, 16'h0042, 16'hFFFF, 16'h0002, 3, 1'b1, 16'h0001, 1'b1);
    check("j_counts", {branch_count, taken_count}, {16'd5, 16'd3});

    // Reset while the request sits in TGT drops it without a flush.
    req_op = 2'b11; pc_plus1 = 16'h0040; offset = 16'h0004; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    check("in_tgt", 32'(m_phase), 32'd2);
    reset = 1'b1;
    step();
    @(negedge clk);
    check("tgt_rst_ready", req_ready, 1'b1);
    check("tgt_rst_valid", redirect_valid, 1'b0);
    check("tgt_rst_flush", flush, 1'b0);
    check("tgt_rst_pc", redirect_pc, 16'h0000);
    check("tgt_rst_counts", {branch_count, taken_count}, 32'h0);
    step();
    reset = 1'b0;
    step();
    @(negedge clk);
    check("post_rst_busy", busy, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = ($urandom_range(0, 1) == 1) ? a : 16'($urandom);
      do_req(2'($urandom_range(0, 3)), a, b, 16'($urandom), 16'($urandom),
             $urandom_range(0, 3), 1'b0, 16'h0, 1'b0);
    end

    // Saturation: preload counters near the ceiling, then retire two taken branches.
    @(negedge clk);
    dut.branch_count_q = 16'hFFFF;
    dut.taken_count_q  = 16'hFFFE;
    m_bc = 16'hFFFF;
    m_tc = 16'hFFFE;
    step();
    do_req(2'b11, 16'h0, 16'h0, 16'h1000, 16'h0010, 0, 1'b1, 16'h1010, 1'b1);
    do_req(2'b00, 16'h5555, 16'h5555, 16'h2000, 16'hFFF0, 1, 1'b1, 16'h1FF0, 1'b1);
    check("sat_counts", {branch_count, taken_count}, 32'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
